count_direction_decoder: RTL and testbench

//   Receive-side companion to the 2-bit binary up/down counter FSM.

---
 rtl/count_direction_decoder_if.sv | 25 ++
 rtl/count_direction_decoder.sv | 126 ++++++++++++
 tb/tb_count_direction_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/count_direction_decoder_if.sv
// Sample/result bundle between a 2-bit up/down counter monitor and its consumer.
// The master drives the counter samples and reads back the decoded direction and position.
interface count_direction_decoder_if #(
    parameter int POS_WIDTH = 8
);
    logic [1:0]           q;
    logic                 valid;
    logic                 clear;
    logic                 dir;
    logic                 moving;
    logic [POS_WIDTH-1:0] position;
    logic                 step_err;
    logic                 fault;
    logic [1:0]           state;

    modport master (
        output q, valid, clear,
        input  dir, moving, position, step_err, fault, state
    );

    modport slave (
        input  q, valid, clear,
        output dir, moving, position, step_err, fault, state
    );
endinterface

// File: rtl/count_direction_decoder.sv
// Decodes up/down/hold steps of a sampled 2-bit binary counter, accumulates position
// and enters a sticky FAULT state after FAULT_LIMIT consecutive illegal (+2) jumps.
module count_direction_decoder #(
    parameter int POS_WIDTH   = 8,
    parameter int FAULT_LIMIT = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    count_direction_decoder_if.slave bus
);
    localparam int ERR_W = $clog2(FAULT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           prev_q, prev_d;
    logic                 dir_q, dir_d;
    logic                 moving_q, moving_d;
    logic [POS_WIDTH-1:0] position_q, position_d;
    logic                 step_err_q, step_err_d;
    logic                 fault_q, fault_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

    logic [1:0]           delta;
    logic                 illegal;
    logic                 limit_hit;

    // Mod-4 difference of consecutive samples: 1 = up, 3 = down, 0 = hold, 2 = illegal.
    assign delta     = bus.q - prev_q;
    assign illegal   = (delta == 2'd2);
    assign limit_hit = (err_cnt_q + ERR_W'(1)) >= ERR_W'(FAULT_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else if (bus.valid) begin
            case (state_q)
                IDLE:    state_d = TRACK;
                TRACK:   if (illegal && limit_hit) state_d = FAULT;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        prev_d     = prev_q;
        dir_d      = dir_q;
        position_d = position_q;
        err_cnt_d  = err_cnt_q;
        moving_d   = 1'b0;
        step_err_d = 1'b0;
        if (bus.clear) begin
            position_d = '0;
            err_cnt_d  = '0;
        end else if (bus.valid) begin
            case (state_q)
                IDLE: prev_d = bus.q;
                TRACK: begin
                    prev_d = bus.q;
                    case (delta)
                        2'd1: begin
                            position_d = position_q + POS_WIDTH'(1);
                            dir_d      = 1'b1;
                            moving_d   = 1'b1;
                            err_cnt_d  = '0;
                        end
                        2'd3: begin
                            position_d = position_q - POS_WIDTH'(1);
                            dir_d      = 1'b0;
                            moving_d   = 1'b1;
                            err_cnt_d  = '0;
                        end
                        2'd2: begin
                            step_err_d = 1'b1;
                            if (err_cnt_q != ERR_W'(FAULT_LIMIT)) err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        default: err_cnt_d = '0;
                    endcase
                end
                default: ;
            endcase
        end
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q     <= 2'b00;
            dir_q      <= 1'b0;
            moving_q   <= 1'b0;
            position_q <= '0;
            step_err_q <= 1'b0;
            fault_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            prev_q     <= prev_d;
            dir_q      <= dir_d;
            moving_q   <= moving_d;
            position_q <= position_d;
            step_err_q <= step_err_d;
            fault_q    <= fault_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.dir      = dir_q;
    assign bus.moving   = moving_q;
    assign bus.position = position_q;
    assign bus.step_err = step_err_q;
    assign bus.fault    = fault_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_count_direction_decoder.sv
// Directed scenarios plus a random sample stream, checked against an arithmetic
// model of the step-decoding rules.
module tb_count_direction_decoder;
    localparam int PW = 8;
    localparam int FL = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    count_direction_decoder_if #(.POS_WIDTH(PW)) bus ();

    count_direction_decoder #(.POS_WIDTH(PW), .FAULT_LIMIT(FL)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // Reference model: mode 0 idle, 1 tracking, 2 faulted.
    int m_mode, m_prev, m_pos, m_dir, m_moving, m_pulse, m_errs;

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_pos = 0; m_dir = 0;
        m_moving = 0; m_pulse = 0; m_errs = 0;
    endtask

    task automatic model_update(input logic v, input logic [1:0] qq, input logic c);
        int d;
        m_moving = 0;
        m_pulse  = 0;
        if (c) begin
            m_mode = 0; m_pos = 0; m_errs = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                m_prev = int'(qq);
                m_mode = 1;
            end else if (m_mode == 1) begin
                d = (int'(qq) - m_prev + 4) % 4;
                m_prev = int'(qq);
                if (d == 1) begin
                    m_pos = (m_pos + 1) % 256; m_dir = 1; m_moving = 1; m_errs = 0;
                end else if (d == 3) begin
                    m_pos = (m_pos + 255) % 256; m_dir = 0; m_moving = 1; m_errs = 0;
                end else if (d == 0) begin
                    m_errs = 0;
                end else begin
                    m_pulse = 1;
                    m_errs  = m_errs + 1;
                    if (m_errs >= FL) m_mode = 2;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(bus.state),    32'(m_mode));
        chk({tag, ".fault"},    32'(bus.fault),    32'(m_mode == 2));
        chk({tag, ".dir"},      32'(bus.dir),      32'(m_dir));
        chk({tag, ".moving"},   32'(bus.moving),   32'(m_moving));
        chk({tag, ".position"}, 32'(bus.position), 32'(m_pos));
        chk({tag, ".step_err"}, 32'(bus.step_err), 32'(m_pulse));
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] qq, input logic c);
        bus.valid = v;
        bus.q     = qq;
        bus.clear = c;
        @(posedge clock);
        model_update(v, qq, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [1:0] seq1 [5];
        logic [1:0] rq;
        logic       rv, rc;
        seq1 = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        bus.valid = 1'b0;
        bus.q     = 2'b00;
        bus.clear = 1'b0;
        model_reset();

        #2;
        check_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // 1: counting up
        foreach (seq1[i]) step("t1", 1'b1, seq1[i], 1'b0);
        chk("t1_pos", 32'(bus.position), 32'h04);
        chk("t1_dir", 32'(bus.dir), 32'd1);

        // 2: hold, then down steps, then repeated hold
        step("t2", 1'b1, 2'b00, 1'b0);
        step("t2", 1'b1, 2'b11, 1'b0);
        step("t2", 1'b1, 2'b10, 1'b0);
        chk("t2_pos", 32'(bus.position), 32'h02);
        step("t2h", 1'b1, 2'b10, 1'b0);
        step("t2h", 1'b1, 2'b10, 1'b0);
        step("t2idle", 1'b0, 2'b01, 1'b0);

        // 3: walk down to 00 then wrap below zero and back
        step("t3", 1'b1, 2'b01, 1'b0);
        step("t3", 1'b1, 2'b00, 1'b0);
        step("t3", 1'b1, 2'b11, 1'b0);
        chk("t3_wrap_dn", 32'(bus.position), 32'hFF);
        step("t3", 1'b1, 2'b00, 1'b0);
        chk("t3_wrap_up", 32'(bus.position), 32'h00);

        // 4: two consecutive illegal jumps enter FAULT
        step("t4a", 1'b1, 2'b10, 1'b0);
        chk("t4_err1", 32'(bus.step_err), 32'd1);
        step("t4b", 1'b1, 2'b00, 1'b0);
        chk("t4_fault", 32'(bus.state), 32'd2);
        step("t4f", 1'b1, 2'b01, 1'b0);
        step("t4f", 1'b1, 2'b10, 1'b0);

        // 5: clear beats valid; first sample after only primes
        step("t5c", 1'b1, 2'b01, 1'b1);
        chk("t5_idle", 32'(bus.state), 32'd0);
        step("t5p", 1'b1, 2'b10, 1'b0);
        step("t5s", 1'b1, 2'b11, 1'b0);

        // 6: async reset mid-cycle at position 5
        step("t6", 1'b1, 2'b00, 1'b0);
        step("t6", 1'b1, 2'b01, 1'b0);
        step("t6", 1'b1, 2'b10, 1'b0);
        step("t6", 1'b1, 2'b11, 1'b0);
        chk("t6_pos5", 32'(bus.position), 32'h05);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("t6_async");
        @(negedge clock);
        reset = 1'b0;
        step("t6_rel", 1'b1, 2'b11, 1'b0);
        chk("t6_track", 32'(bus.state), 32'd1);

        // random stream
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rq = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 15) == 0);
            step("rand", rv, rq, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
